// File: rtl/ntt_pkg.sv
// Shared NTT definitions: split-mode encodings, group geometry and the
// splitter FSM state type. The merger imports the same package.
package ntt_pkg;

    // Split-mode encodings carried on split_sel.
    localparam logic [2:0] MODE_FLAT    = 3'd0;  // one group of 257, one beat
    localparam logic [2:0] MODE_G17     = 3'd1;  // 15 groups of 17, one beat
    localparam logic [2:0] MODE_G5      = 3'd2;  // 51 groups of 5, one beat
    localparam logic [2:0] MODE_RSVD3   = 3'd3;  // reserved, treated as flat
    localparam logic [2:0] MODE_FLAT_2B = 3'd4;  // one group of 257, two beats
    localparam logic [2:0] MODE_G17_2B  = 3'd5;  // 15 groups of 17, two beats
    localparam logic [2:0] MODE_G5_2B   = 3'd6;  // 51 groups of 5, two beats
    localparam logic [2:0] MODE_RSVD7   = 3'd7;  // reserved, treated as flat

    // Group lengths in words.
    localparam int GLEN_FLAT = 257;
    localparam int GLEN_17   = 17;
    localparam int GLEN_5    = 5;

    // Group counts per list.
    localparam int GCNT_FLAT = 1;
    localparam int GCNT_17   = 15;
    localparam int GCNT_5    = 51;

    // Splitter output FSM.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } split_state_t;

    // Modes 4..6 deliver the list as two beats (second adder operand set).
    function automatic logic is_two_beat(input logic [2:0] sel);
        return (sel == MODE_FLAT_2B) || (sel == MODE_G17_2B) || (sel == MODE_G5_2B);
    endfunction

    // Reserved encodings fall back to the flat mapping but are flagged.
    function automatic logic is_reserved(input logic [2:0] sel);
        return (sel == MODE_RSVD3) || (sel == MODE_RSVD7);
    endfunction

endpackage

// File: rtl/split_map.sv
// Combinational word router: maps one input list onto the butterfly operand
// words and the adder-lane words for beat 0 and beat 1 of the selected mode.
module split_map
    import ntt_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 257,
    parameter int N_ADDERS = 51
) (
    input  logic [SIZE*WIDTH-1:0]     i_list,
    input  logic [2:0]                i_sel,
    output logic [(SIZE-1)*WIDTH-1:0] o_bfa,
    output logic [N_ADDERS*WIDTH-1:0] o_adder_b0,
    output logic [N_ADDERS*WIDTH-1:0] o_adder_b1,
    output logic                      o_two_beat,
    output logic                      o_reserved
);

    localparam int IW = SIZE * WIDTH;
    localparam int BW = (SIZE - 1) * WIDTH;
    localparam int AW = N_ADDERS * WIDTH;

    // Butterfly words: group g owns bfa words (len-1)*g .. (len-1)*g+len-2,
    // fed from in[len*g+1 ..]. In two-beat modes the leading word of each
    // group travels on the adder lane instead, so its bfa slot is zeroed.
    // When the groups do not cover the whole list, the last two input
    // words land on the top two bfa words.
    function automatic logic [BW-1:0] map_bfa(
        input logic [IW-1:0] din,
        input int            len,
        input int            grp,
        input logic          zero_lead
    );
        logic [BW-1:0] res;
        int            g;
        int            j;
        res = '0;
        for (int k = 0; k < SIZE - 1; k++) begin
            g = k / (len - 1);
            j = k % (len - 1);
            if (g < grp) begin
                if (!(zero_lead && (j == 0))) begin
                    res[k*WIDTH +: WIDTH] = din[(len*g + 1 + j)*WIDTH +: WIDTH];
                end
            end else if ((len != SIZE) && (k >= SIZE - 3)) begin
                res[k*WIDTH +: WIDTH] = din[(k + 1)*WIDTH +: WIDTH];
            end
        end
        return res;
    endfunction

    // Adder words: lane g takes word len*g+off of the list; unused lanes are 0.
    function automatic logic [AW-1:0] map_adder(
        input logic [IW-1:0] din,
        input int            len,
        input int            grp,
        input int            off
    );
        logic [AW-1:0] res;
        res = '0;
        for (int g = 0; g < N_ADDERS; g++) begin
            if (g < grp) begin
                res[g*WIDTH +: WIDTH] = din[(len*g + off)*WIDTH +: WIDTH];
            end
        end
        return res;
    endfunction

    // Select the mapping for the requested mode; reserved codes map as flat.
    always_comb begin
        o_bfa      = '0;
        o_adder_b0 = '0;
        o_adder_b1 = '0;
        o_two_beat = is_two_beat(i_sel);
        o_reserved = is_reserved(i_sel);
        case (i_sel)
            MODE_G17: begin
                o_bfa      = map_bfa(i_list, GLEN_17, GCNT_17, 1'b0);
                o_adder_b0 = map_adder(i_list, GLEN_17, GCNT_17, 0);
            end
            MODE_G5: begin
                o_bfa      = map_bfa(i_list, GLEN_5, GCNT_5, 1'b0);
                o_adder_b0 = map_adder(i_list, GLEN_5, GCNT_5, 0);
            end
            MODE_FLAT_2B: begin
                o_bfa      = map_bfa(i_list, GLEN_FLAT, GCNT_FLAT, 1'b1);
                o_adder_b0 = map_adder(i_list, GLEN_FLAT, GCNT_FLAT, 0);
                o_adder_b1 = map_adder(i_list, GLEN_FLAT, GCNT_FLAT, 1);
            end
            MODE_G17_2B: begin
                o_bfa      = map_bfa(i_list, GLEN_17, GCNT_17, 1'b1);
                o_adder_b0 = map_adder(i_list, GLEN_17, GCNT_17, 0);
                o_adder_b1 = map_adder(i_list, GLEN_17, GCNT_17, 1);
            end
            MODE_G5_2B: begin
                o_bfa      = map_bfa(i_list, GLEN_5, GCNT_5, 1'b1);
                o_adder_b0 = map_adder(i_list, GLEN_5, GCNT_5, 0);
                o_adder_b1 = map_adder(i_list, GLEN_5, GCNT_5, 1);
            end
            default: begin
                o_bfa      = map_bfa(i_list, GLEN_FLAT, GCNT_FLAT, 1'b0);
                o_adder_b0 = map_adder(i_list, GLEN_FLAT, GCNT_FLAT, 0);
            end
        endcase
    end

endmodule

// File: rtl/splitter.sv
// List splitter: accepts one list per handshake, routes it through split_map
// and presents it as one or two registered output beats.
module splitter
    import ntt_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 257,
    parameter int N_ADDERS = 51
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SIZE*WIDTH-1:0]     in_list,
    input  logic [2:0]                split_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [(SIZE-1)*WIDTH-1:0] bfa_in,
    output logic [N_ADDERS*WIDTH-1:0] adder_in,
    output logic                      out_last,
    output logic                      sel_err,
    output logic [1:0]                dbg_state
);

    // Handshake: a list is taken on a cycle where in_valid && in_ready; a beat
    // is taken on a cycle where out_valid && out_ready. valid never waits on
    // ready, and once out_valid is high the beat holds until consumed.

    split_state_t                r_state;
    logic                        r_out_valid;
    logic                        r_out_last;
    logic                        r_sel_err;
    logic                        r_two_beat;
    logic [(SIZE-1)*WIDTH-1:0]   r_bfa;
    logic [N_ADDERS*WIDTH-1:0]   r_adder;
    logic [N_ADDERS*WIDTH-1:0]   r_adder_b1;

    logic [(SIZE-1)*WIDTH-1:0]   w_bfa;
    logic [N_ADDERS*WIDTH-1:0]   w_adder_b0;
    logic [N_ADDERS*WIDTH-1:0]   w_adder_b1;
    logic                        w_two_beat;
    logic                        w_reserved;
    logic                        w_accept;
    logic                        w_consume;

    split_map #(
        .WIDTH    (WIDTH),
        .SIZE     (SIZE),
        .N_ADDERS (N_ADDERS)
    ) u_map (
        .i_list     (in_list),
        .i_sel      (split_sel),
        .o_bfa      (w_bfa),
        .o_adder_b0 (w_adder_b0),
        .o_adder_b1 (w_adder_b1),
        .o_two_beat (w_two_beat),
        .o_reserved (w_reserved)
    );

    // Ready when idle, or when the last beat of the current list leaves this
    // cycle; depends only on registered state and out_ready.
    assign in_ready  = ~rst & ((r_state == EMPTY) | (out_ready & r_out_last));
    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_out_valid & out_ready;

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign sel_err   = r_sel_err;
    assign bfa_in    = r_bfa;
    assign adder_in  = r_adder;
    assign dbg_state = r_state;

    // Output FSM and operand registers; a new list is loaded whenever one is
    // accepted, which also covers a last-beat consume on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_sel_err   <= 1'b0;
            r_two_beat  <= 1'b0;
            r_bfa       <= '0;
            r_adder     <= '0;
            r_adder_b1  <= '0;
        end else begin
            r_sel_err <= w_accept & w_reserved;
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state     <= BEAT0;
                        r_out_valid <= 1'b1;
                        r_out_last  <= ~w_two_beat;
                        r_two_beat  <= w_two_beat;
                        r_bfa       <= w_bfa;
                        r_adder     <= w_adder_b0;
                        r_adder_b1  <= w_adder_b1;
                    end
                end
                BEAT0: begin
                    if (w_consume) begin
                        if (r_two_beat) begin
                            // bfa words stay as loaded; only the adder set changes
                            r_state    <= BEAT1;
                            r_out_last <= 1'b1;
                            r_adder    <= r_adder_b1;
                        end else if (w_accept) begin
                            r_state     <= BEAT0;
                            r_out_valid <= 1'b1;
                            r_out_last  <= ~w_two_beat;
                            r_two_beat  <= w_two_beat;
                            r_bfa       <= w_bfa;
                            r_adder     <= w_adder_b0;
                            r_adder_b1  <= w_adder_b1;
                        end else begin
                            r_state     <= EMPTY;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                BEAT1: begin
                    if (w_consume) begin
                        if (w_accept) begin
                            r_state     <= BEAT0;
                            r_out_valid <= 1'b1;
                            r_out_last  <= ~w_two_beat;
                            r_two_beat  <= w_two_beat;
                            r_bfa       <= w_bfa;
                            r_adder     <= w_adder_b0;
                            r_adder_b1  <= w_adder_b1;
                        end else begin
                            r_state     <= EMPTY;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/splitter.md
SPLITTER -- requirements
Module: splitter

Interface
REQ-001 SHALL have parameters: WIDTH, default 32, word width; SIZE, default 257, list length in words; N_ADDERS, default 51, adder lanes.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have: in_valid  in  1  input list valid.
REQ-005 SHALL have: in_ready  out  1  input accepted when in_valid and in_ready are both high.
REQ-006 SHALL have: in_list  in  SIZE*WIDTH  input list; word k at bits [(k+1)*WIDTH-1 -: WIDTH].
REQ-007 SHALL have: split_sel  in  3  split mode, sampled only at acceptance.
REQ-008 SHALL have: out_valid  out  1  output beat valid.
REQ-009 SHALL have: out_ready  in  1  beat consumed when out_valid and out_ready are both high.
REQ-010 SHALL have: bfa_in  out  (SIZE-1)*WIDTH  butterfly/multiplier operand words.
REQ-011 SHALL have: adder_in  out  N_ADDERS*WIDTH  adder-lane operand words.
REQ-012 SHALL have: out_last  out  1  final beat of the current list.
REQ-013 SHALL have: sel_err  out  1  one-cycle pulse when a reserved mode is accepted.

Function
REQ-014 Mode 0 and reserved modes 3 and 7: single beat; adder word 0 = in[0]; bfa word k = in[k+1] for k 0..255; all other adder words 0.
REQ-015 Mode 1: single beat; for group g 0..14: adder word g = in[17g]; bfa words 16g..16g+15 = in[17g+1..17g+16].
REQ-016 Mode 2: single beat; for group g 0..50: adder word g = in[5g]; bfa words 4g..4g+3 = in[5g+1..5g+4].
REQ-017 Modes 1 and 2, tail: bfa word 254 = in[255]; bfa word 255 = in[256]; all unmapped bfa and adder words 0.
REQ-018 Modes 4, 5 and 6: two beats, with group length L = 257, 17 or 5 and group count G = 1, 15 or 51 respectively.
REQ-019 Modes 4-6, beat 0: adder word g = in[L*g]; beat 1: adder word g = in[L*g+1].
REQ-020 Modes 4-6: bfa word (L-1)*g+j = in[L*g+1+j] for j 1..L-2; bfa word (L-1)*g = 0; tail and unmapped words follow REQ-017 (mode 4: no tail).
REQ-021 bfa_in SHALL be identical on beat 0 and beat 1 of the same list.
REQ-022 Mode 4 and mode 0 SHALL treat the 257 words as a single group.
REQ-023 FSM states: EMPTY, BEAT0, BEAT1.
REQ-024 Transitions: EMPTY to BEAT0 on accept; BEAT0 to EMPTY on consume in single-beat modes; BEAT0 to BEAT1 on consume in two-beat modes; BEAT1 to EMPTY on consume.
REQ-025 Any consume of a last beat coinciding with a new accept SHALL go to BEAT0 instead of EMPTY.
REQ-026 in_ready = (state==EMPTY) or (out_ready and out_last); no combinational path from in_valid to in_ready.
REQ-027 Latency: out_valid SHALL rise the cycle after acceptance; back-to-back single-beat lists give one list per cycle.
REQ-028 out_valid is high in BEAT0 and BEAT1; out_last is high in BEAT0 for single-beat modes and in BEAT1 otherwise.
REQ-029 Under stall (out_ready low), all outputs SHALL hold stable.

Reset
REQ-030 While rst is high: state = EMPTY, out_valid = 0, out_last = 0, sel_err = 0, bfa_in = 0, adder_in = 0, and in_ready = 0.
REQ-031 A reset asserted mid-list SHALL discard the list with no further beats.
REQ-032 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-033 The mode encodings (0,1,2,4,5,6), the group lengths (257/17/5), the group counts (1/15/51) and the FSM state type SHALL live in the shared NTT package, which the merger also uses.
REQ-034 The design SHALL use one combinational sub-module, split_map, producing the beat-0 and beat-1 mappings; splitter holds the FSM and registers.

Verification
REQ-035 Mode 0, in[k]=k: bfa word k = k+1; adder word 0 = 0; out_last = 1 on the first beat.
REQ-036 Mode 2, in[k]=k: adder word 3 = 15; bfa word 4 = 6; bfa word 255 = 256; bfa word 210 = 0.
REQ-037 Mode 5, in[k]=k: beat 0 adder word 2 = 34; beat 1 adder word 2 = 35; bfa word 32 = 0; bfa word 33 = 36.
REQ-038 Mode 6 with out_ready low for 3 cycles on beat 1: outputs held; in_ready = 0 until beat 1 is consumed.
REQ-039 Mode 1 lists on consecutive cycles with out_ready = 1: one out_valid per cycle and in_ready constantly 1.
REQ-040 rst in BEAT0 of mode 4, then mode 3 accepted: no beat 1 is emitted; sel_err pulses once; mode-0 mapping applies.
